// File: rtl/pc_branch_unit.sv
// pc_branch_unit
// Program counter, link register and branch/jump resolution for the 16-bit CPU.
// Sits between decode/register-read and instruction fetch.
//
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   stall_i             hold all state this cycle (wins over instr_valid_i)
//   instr_valid_i       op fields are valid this cycle
//   op_kind_i           00 SEQ, 01 JCOND (absolute), 10 BCOND (relative), 11 JAL
//   ret_i               return via link (or return-stack top when enabled)
//   cond_i, flags_i     condition code and flags {N,Z,F,L,C}
//   target_i, disp_i    absolute target and two's-complement displacement
//   pc_o                registered program counter
//   pc_next_o           combinational next PC
//   link_o              link register (written by JAL)
//   redirect_o          one-cycle pulse: previous accepted op changed flow
//   ras_empty_o         return stack empty (constant 1 without the stack)
//   ras_underflow_o     one-cycle pulse: return with empty stack
//
// Build option: define PC_BRANCH_UNIT_RAS_EN to add a RAS_DEPTH-entry
// circular return stack; otherwise returns always use link_o.
module pc_branch_unit #(
  parameter int                 ADDR_W    = 16,
  parameter int                 DISP_W    = 8,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
  parameter int                 RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_i,
  input  logic              instr_valid_i,
  input  logic [1:0]        op_kind_i,
  input  logic              ret_i,
  input  logic [3:0]        cond_i,
  input  logic [4:0]        flags_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic [DISP_W-1:0] disp_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_next_o,
  output logic [ADDR_W-1:0] link_o,
  output logic              redirect_o,
  output logic              ras_empty_o,
  output logic              ras_underflow_o
);

  localparam logic [1:0] OP_SEQ   = 2'b00;
  localparam logic [1:0] OP_JCOND = 2'b01;
  localparam logic [1:0] OP_BCOND = 2'b10;
  localparam logic [1:0] OP_JAL   = 2'b11;

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RAS_DEPTH must be a power of two and at least 2");
  end

  // Flags: [0]C [1]L [2]F [3]Z [4]N
  function automatic logic cond_true(input logic [3:0] c, input logic [4:0] f);
    logic cf, lf, ff, zf, nf;
    cf = f[0]; lf = f[1]; ff = f[2]; zf = f[3]; nf = f[4];
    case (c)
      4'h0:    cond_true = zf;
      4'h1:    cond_true = !zf;
      4'h2:    cond_true = cf;
      4'h3:    cond_true = !cf;
      4'h4:    cond_true = lf;
      4'h5:    cond_true = !lf;
      4'h6:    cond_true = nf;
      4'h7:    cond_true = !nf;
      4'h8:    cond_true = ff;
      4'h9:    cond_true = !ff;
      4'hA:    cond_true = !lf && !zf;
      4'hB:    cond_true = lf || zf;
      4'hC:    cond_true = !nf && !zf;
      4'hD:    cond_true = nf || zf;
      4'hE:    cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  endfunction

  logic [ADDR_W-1:0]        pc_q, pc_d, link_q, link_d;
  logic                     redirect_q, redirect_d, underflow_q, underflow_d;
  logic [ADDR_W-1:0]        pc_inc, pc_br, ret_tgt;
  logic signed [ADDR_W-1:0] disp_ext;
  logic                     accept, taken, push;

  assign accept   = instr_valid_i && !stall_i;
  assign taken    = cond_true(cond_i, flags_i);
  assign pc_inc   = pc_q + ADDR_W'(1);
  // Sign-extend the displacement; the add wraps modulo 2^ADDR_W.
  assign disp_ext = ADDR_W'(signed'(disp_i));
  assign pc_br    = pc_q + $unsigned(disp_ext);
  // A return overrides op_kind, so it never links or pushes.
  assign push     = accept && !ret_i && (op_kind_i == OP_JAL);

`ifdef PC_BRANCH_UNIT_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d;      // next slot to write; top is sp_q-1
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              ras_empty, pop;

  assign ras_empty   = (cnt_q == '0);
  assign pop         = accept && ret_i && !ras_empty;
  assign ret_tgt     = ras_empty ? link_q : ras_mem_q[sp_q - PTR_W'(1)];
  assign underflow_d = accept && ret_i && ras_empty;
  assign ras_empty_o = ras_empty;

  // When full, a push overwrites the oldest slot and the count saturates.
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (push) begin
      sp_d = sp_q + PTR_W'(1);
      if (cnt_q != (PTR_W+1)'(RAS_DEPTH)) cnt_d = cnt_q + (PTR_W+1)'(1);
    end else if (pop) begin
      sp_d  = sp_q - PTR_W'(1);
      cnt_d = cnt_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ras_mem_q[sp_q] <= pc_inc;
  end
`else
  assign ret_tgt     = link_q;
  assign underflow_d = 1'b0;
  assign ras_empty_o = 1'b1;
`endif

  always_comb begin
    pc_d   = pc_q;
    link_d = link_q;
    if (accept) begin
      if (ret_i) begin
        pc_d = ret_tgt;
      end else begin
        case (op_kind_i)
          OP_JCOND: pc_d = taken ? target_i : pc_inc;
          OP_BCOND: pc_d = taken ? pc_br : pc_inc;
          OP_JAL: begin
            pc_d   = target_i;
            link_d = pc_inc;
          end
          default:  pc_d = pc_inc;
        endcase
      end
    end
  end

  // Landing on pc+1 is not a flow change, whatever the op was.
  assign redirect_d = accept && (pc_d != pc_inc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_VEC;
      link_q      <= '0;
      redirect_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      link_q      <= link_d;
      redirect_q  <= redirect_d;
      underflow_q <= underflow_d;
    end
  end

  assign pc_o            = pc_q;
  assign pc_next_o       = pc_d;
  assign link_o          = link_q;
  assign redirect_o      = redirect_q;
  assign ras_underflow_o = underflow_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
module tb_pc_branch_unit;
`ifdef PC_BRANCH_UNIT_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  localparam logic [1:0] SEQ = 2'b00, JC = 2'b01, BC = 2'b10, JAL = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n, stall, valid, ret;
  logic [1:0]  kind;
  logic [3:0]  cond;
  logic [4:0]  flags;
  logic [15:0] target;
  logic [7:0]  disp;
  logic [15:0] pc_o, pc_next_o, link_o;
  logic        redirect_o, ras_empty_o, ras_underflow_o;

  pc_branch_unit #(.ADDR_W(16), .DISP_W(8), .RESET_VEC(16'h0010), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .stall_i(stall), .instr_valid_i(valid),
    .op_kind_i(kind), .ret_i(ret), .cond_i(cond), .flags_i(flags),
    .target_i(target), .disp_i(disp), .pc_o(pc_o), .pc_next_o(pc_next_o),
    .link_o(link_o), .redirect_o(redirect_o), .ras_empty_o(ras_empty_o),
    .ras_underflow_o(ras_underflow_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] link;
    logic        red;
    logic        uf;
    logic        emp;
  } st_t;

  st_t         st_q[$];
  logic [15:0] nx_q[$];
  int          checks = 0, errors = 0;
  logic [15:0] cur_pc = 16'h0010, cur_link = 16'h0000;
  logic        cur_emp = 1'b1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Post-edge state monitor
  always @(posedge clk) begin : mon_state
    st_t e;
    #1;
    if (st_q.size() > 0) begin
      e = st_q.pop_front();
      chk("pc_o", pc_o, e.pc);
      chk("link_o", link_o, e.link);
      chk("redirect_o", 16'(redirect_o), 16'(e.red));
      chk("ras_underflow_o", 16'(ras_underflow_o), 16'(e.uf));
      chk("ras_empty_o", 16'(ras_empty_o), 16'(e.emp));
    end
  end

  // Combinational next-PC monitor, mid low phase
  always @(negedge clk) begin : mon_next
    #2;
    if (nx_q.size() > 0) chk("pc_next_o", pc_next_o, nx_q.pop_front());
  end

  task automatic cyc(input logic v, s, r, input logic [1:0] k, input logic [3:0] c,
                     input logic [4:0] f, input logic [15:0] t, input logic [7:0] d,
                     input logic [15:0] e_nx, e_pc, e_link, input logic e_red, e_uf, e_emp);
    st_t e;
    @(negedge clk);
    valid = v; stall = s; ret = r; kind = k; cond = c; flags = f; target = t; disp = d;
    nx_q.push_back(e_nx);
    e.pc = e_pc; e.link = e_link; e.red = e_red; e.uf = e_uf; e.emp = e_emp;
    st_q.push_back(e);
    cur_pc = e_pc; cur_link = e_link; cur_emp = e_emp;
  endtask

  task automatic jmp(input logic [15:0] t);
    logic [15:0] inc;
    inc = cur_pc + 16'h1;
    cyc(1, 0, 0, JC, 4'hE, 5'h00, t, 8'h00, t, t, cur_link, t != inc, 1'b0, cur_emp);
  endtask

  task automatic idle();
    cyc(0, 0, 0, SEQ, 4'h0, 5'h00, 16'h0, 8'h00, cur_pc, cur_pc, cur_link, 1'b0, 1'b0, cur_emp);
  endtask

  function automatic logic cref(input logic [3:0] c, input logic [4:0] f);
    logic C, L, F, Z, N;
    {N, Z, F, L, C} = f;
    case (c)
      4'h0: return Z;        4'h1: return !Z;
      4'h2: return C;        4'h3: return !C;
      4'h4: return L;        4'h5: return !L;
      4'h6: return N;        4'h7: return !N;
      4'h8: return F;        4'h9: return !F;
      4'hA: return !L && !Z; 4'hB: return L || Z;
      4'hC: return !N && !Z; 4'hD: return N || Z;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic [15:0] rt [5];
  logic        re [5];
  logic        ru [5];
  logic [15:0] nx, t;

  initial begin
    reset_n = 1'b0; stall = 0; valid = 0; ret = 0; kind = SEQ; cond = 0; flags = 0;
    target = 0; disp = 0;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc_o, 16'h0010);
    chk("rst_link", link_o, 16'h0000);
    chk("rst_redirect", 16'(redirect_o), 16'h0);
    chk("rst_underflow", 16'(ras_underflow_o), 16'h0);
    chk("rst_empty", 16'(ras_empty_o), 16'h1);
    reset_n = 1'b1;

    // sequential flow
    cyc(1, 0, 0, SEQ, 4'h0, 5'h00, 16'h0, 8'h00, 16'h0011, 16'h0011, 16'h0, 0, 0, 1);
    cyc(1, 0, 0, SEQ, 4'h0, 5'h00, 16'h0, 8'h00, 16'h0012, 16'h0012, 16'h0, 0, 0, 1);
    cyc(1, 0, 0, SEQ, 4'h0, 5'h00, 16'h0, 8'h00, 16'h0013, 16'h0013, 16'h0, 0, 0, 1);

    // relative branch, taken (negative disp) then idle, then not taken
    jmp(16'h0040);
    cyc(1, 0, 0, BC, 4'h0, 5'b01000, 16'h0, 8'hFC, 16'h003C, 16'h003C, 16'h0, 1, 0, 1);
    idle();
    jmp(16'h0040);
    cyc(1, 0, 0, BC, 4'h0, 5'b00000, 16'h0, 8'hFC, 16'h0041, 16'h0041, 16'h0, 0, 0, 1);

    // JAL and return
    jmp(16'h0100);
    cyc(1, 0, 0, JAL, 4'h0, 5'h00, 16'h0200, 8'h00, 16'h0200, 16'h0200, 16'h0101, 1, 0, !RAS);
    cyc(1, 0, 1, SEQ, 4'h0, 5'h00, 16'h0, 8'h00, 16'h0101, 16'h0101, 16'h0101, 1, 0, 1);

    // stall holds everything, then the jump happens once
    repeat (3)
      cyc(1, 1, 0, JAL, 4'h0, 5'h00, 16'h0300, 8'h00, 16'h0101, 16'h0101, 16'h0101, 0, 0, 1);
    cyc(1, 0, 0, JAL, 4'h0, 5'h00, 16'h0300, 8'h00, 16'h0300, 16'h0300, 16'h0102, 1, 0, !RAS);
    idle();
    cyc(1, 0, 1, SEQ, 4'h0, 5'h00, 16'h0, 8'h00, 16'h0102, 16'h0102, 16'h0102, 1, 0, 1);

    // wrap-around and branch-to-pc+1
    jmp(16'hFFFF);
    cyc(1, 0, 0, SEQ, 4'h0, 5'h00, 16'h0, 8'h00, 16'h0000, 16'h0000, 16'h0102, 0, 0, 1);
    jmp(16'h0002);
    cyc(1, 0, 0, BC, 4'hE, 5'h00, 16'h0, 8'hFE, 16'h0000, 16'h0000, 16'h0102, 1, 0, 1);
    cyc(1, 0, 0, BC, 4'hE, 5'h00, 16'h0, 8'h01, 16'h0001, 16'h0001, 16'h0102, 0, 0, 1);

    // condition sweep with absolute jumps to 0x1234
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 32; f++) begin
        nx = cref(4'(c), 5'(f)) ? 16'h1234 : 16'(cur_pc + 16'h1);
        cyc(1, 0, 0, JC, 4'(c), 5'(f), 16'h1234, 8'h00, nx, nx, cur_link,
            nx != 16'(cur_pc + 16'h1), 0, 1);
      end
    end

    // ret overrides kind/cond; stack is empty here
    nx = 16'h0102;
    cyc(1, 0, 1, BC, 4'hF, 5'h00, 16'h0, 8'h00, nx, nx, 16'h0102,
        nx != 16'(cur_pc + 16'h1), RAS, 1);

    // five nested calls, five returns
    jmp(16'h0010);
    for (int i = 1; i <= 5; i++) begin
      t = 16'((i + 1) * 16);
      cyc(1, 0, 0, JAL, 4'h0, 5'h00, t, 8'h00, t, t, 16'(cur_pc + 16'h1), 1, 0, !RAS);
    end
    if (RAS) begin
      rt = '{16'h0051, 16'h0041, 16'h0031, 16'h0021, 16'h0051};
      re = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      ru = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    end else begin
      rt = '{16'h0051, 16'h0051, 16'h0051, 16'h0051, 16'h0051};
      re = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      ru = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    end
    for (int i = 0; i < 5; i++)
      cyc(1, 0, 1, SEQ, 4'h0, 5'h00, 16'h0, 8'h00, rt[i], rt[i], 16'h0051,
          rt[i] != 16'(cur_pc + 16'h1), ru[i], re[i]);
    cyc(1, 0, 0, JAL, 4'h0, 5'h00, 16'h0080, 8'h00, 16'h0080, 16'h0080, 16'h0052, 1, 0, !RAS);

    // asynchronous reset between edges
    @(negedge clk);
    valid = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    chk("async_pc", pc_o, 16'h0010);
    chk("async_link", link_o, 16'h0000);
    chk("async_redirect", 16'(redirect_o), 16'h0);
    chk("async_empty", 16'(ras_empty_o), 16'h1);
    @(negedge clk);
    reset_n = 1'b1;
    cur_pc = 16'h0010; cur_link = 16'h0000; cur_emp = 1'b1;
    cyc(1, 0, 0, SEQ, 4'h0, 5'h00, 16'h0, 8'h00, 16'h0011, 16'h0011, 16'h0, 0, 0, 1);
    idle();

    @(posedge clk);
    #3;
    chk("state_queue_left", 16'(st_q.size()), 16'h0);
    chk("next_queue_left", 16'(nx_q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
